// File: rtl/product_accumulator.sv
// product_accumulator
// Sums CNT consecutive unsigned products taken over a valid/ready handshake.
// The block sum saturates at 2^AW-1 and a sticky overflow flag records it.
// The result is held on acc_valid/acc_ready until the consumer takes it.
module product_accumulator #(
    parameter int PW  = 8,
    parameter int AW  = 10,
    parameter int CNT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          p_valid,
    input  logic [PW-1:0] p_data,
    output logic          p_ready,
    output logic          acc_valid,
    output logic [AW-1:0] acc_data,
    output logic          acc_ovf,
    input  logic          acc_ready
);

    localparam int CW = $clog2(CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] acc_reg, acc_next;
    logic [CW-1:0] count_reg, count_next;
    logic          ovf_reg, ovf_next;

    logic          accept;
    logic          xfer;
    logic [AW-1:0] p_ext;
    logic [AW:0]   sum_wide;
    logic [CW-1:0] count_inc;

    // The product is zero-extended to the accumulator width; the sum is formed
    // one bit wider so the carry out flags saturation.
    assign p_ext     = AW'(p_data);
    assign sum_wide  = {1'b0, acc_reg} + {1'b0, p_ext};
    assign count_inc = count_reg + CW'(1);
    assign accept    = p_valid & p_ready;
    assign xfer      = acc_valid & acc_ready;

    // State and datapath registers; rst returns everything to the empty state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Next-state and datapath update; clear overrides any accept or transfer.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
        ovf_next   = ovf_reg;
        if (clear) begin
            state_next = IDLE;
            acc_next   = '0;
            count_next = '0;
            ovf_next   = 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (accept) begin
                        acc_next   = p_ext;
                        count_next = CW'(1);
                        ovf_next   = 1'b0;
                        state_next = (CNT == 1) ? HOLD : ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        // Once saturated, acc is all ones so any further
                        // non-zero product carries out again and it stays put.
                        if (sum_wide[AW]) begin
                            acc_next = '1;
                            ovf_next = 1'b1;
                        end else begin
                            acc_next = sum_wide[AW-1:0];
                        end
                        count_next = count_inc;
                        if (count_inc == CNT_LAST) begin
                            state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (xfer) begin
                        state_next = IDLE;
                        count_next = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Handshake and result outputs decoded from the registered state.
    always_comb begin
        p_ready   = (state_reg != HOLD);
        acc_valid = (state_reg == HOLD);
        acc_data  = acc_reg;
        acc_ovf   = ovf_reg;
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Testbench for product_accumulator: instance 0 uses AW=10, instance 1 uses AW=9
// for the saturation case. Expected block results go into per-instance queues
// when products are accepted and are popped when the DUT transfers a sum.
module tb_product_accumulator;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       p_valid   [2];
    logic [7:0] p_data    [2];
    logic       p_ready   [2];
    logic       acc_valid [2];
    logic       acc_ovf   [2];
    logic       acc_ready [2];
    logic [9:0] acc_data_a;
    logic [8:0] acc_data_b;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_q0[$];
    int exp_q1[$];
    int m_sum [2];
    int m_cnt [2];
    int m_ovf [2];

    product_accumulator #(.PW(8), .AW(10), .CNT(4)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .p_valid   (p_valid[0]),
        .p_data    (p_data[0]),
        .p_ready   (p_ready[0]),
        .acc_valid (acc_valid[0]),
        .acc_data  (acc_data_a),
        .acc_ovf   (acc_ovf[0]),
        .acc_ready (acc_ready[0])
    );

    product_accumulator #(.PW(8), .AW(9), .CNT(4)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .p_valid   (p_valid[1]),
        .p_data    (p_data[1]),
        .p_ready   (p_ready[1]),
        .acc_valid (acc_valid[1]),
        .acc_data  (acc_data_b),
        .acc_ovf   (acc_ovf[1]),
        .acc_ready (acc_ready[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: saturating block sum of 4 products.
    task automatic model_add(input int k, input int d);
        int maxv;
        maxv = (k == 0) ? 1023 : 511;
        if (m_cnt[k] == 0) begin
            m_sum[k] = d;
            m_ovf[k] = 0;
        end else begin
            m_sum[k] = m_sum[k] + d;
            if (m_sum[k] > maxv) begin
                m_sum[k] = maxv;
                m_ovf[k] = 1;
            end
        end
        m_cnt[k]++;
        if (m_cnt[k] == 4) begin
            if (k == 0) exp_q0.push_back(m_ovf[k] * 65536 + m_sum[k]);
            else        exp_q1.push_back(m_ovf[k] * 65536 + m_sum[k]);
            m_cnt[k] = 0;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int k, input int d);
        int n;
        n = 0;
        p_valid[k] = 1'b1;
        p_data[k]  = 8'(d);
        @(negedge clk);
        while (!p_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!p_ready[k]) begin
            check("accept_timeout", 32'(p_ready[k]), 32'd1);
        end else begin
            model_add(k, d);
        end
        @(posedge clk);
        #1;
        p_valid[k] = 1'b0;
    endtask

    // Output monitors: a transfer happens on the next edge when these hold.
    always @(negedge clk) begin
        int e;
        if (!rst && !clear && acc_valid[0] && acc_ready[0]) begin
            if (exp_q0.size() == 0) begin
                check("a_unexpected_out", 32'd1, 32'd0);
            end else begin
                e = exp_q0.pop_front();
                $display("xfer a: data=%0d ovf=%0d", acc_data_a, acc_ovf[0]);
                check("a_data", 32'(acc_data_a), 32'(e & 'hffff));
                check("a_ovf", 32'(acc_ovf[0]), 32'(e >> 16));
            end
        end
    end

    always @(negedge clk) begin
        int e;
        if (!rst && !clear && acc_valid[1] && acc_ready[1]) begin
            if (exp_q1.size() == 0) begin
                check("b_unexpected_out", 32'd1, 32'd0);
            end else begin
                e = exp_q1.pop_front();
                $display("xfer b: data=%0d ovf=%0d", acc_data_b, acc_ovf[1]);
                check("b_data", 32'(acc_data_b), 32'(e & 'hffff));
                check("b_ovf", 32'(acc_ovf[1]), 32'(e >> 16));
            end
        end
    end

    initial begin
        int bv [7];
        int bd [7];
        bv = '{1, 0, 0, 1, 0, 1, 1};
        bd = '{3, 0, 0, 4, 0, 5, 6};
        for (int k = 0; k < 2; k++) begin
            p_valid[k]   = 1'b0;
            p_data[k]    = 8'd0;
            acc_ready[k] = 1'b1;
            m_sum[k]     = 0;
            m_cnt[k]     = 0;
            m_ovf[k]     = 0;
        end
        clear = 1'b0;
        rst   = 1'b1;

        // Reset state
        #2;
        check("rst_p_ready", 32'(p_ready[0]), 32'd1);
        check("rst_acc_valid", 32'(acc_valid[0]), 32'd0);
        check("rst_acc_data", 32'(acc_data_a), 32'd0);
        check("rst_acc_ovf", 32'(acc_ovf[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: basic sum, result visible one cycle after the 4th accept
        send(0, 10); send(0, 20); send(0, 30); send(0, 40);
        check("t1_latency", 32'(acc_valid[0]), 32'd1);
        @(posedge clk); #1;
        check("t1_back_idle", 32'(acc_valid[0]), 32'd0);
        check("t1_p_ready", 32'(p_ready[0]), 32'd1);

        // 2: saturation on the AW=9 instance, then a clean block
        send(1, 255); send(1, 255); send(1, 255); send(1, 255);
        send(1, 1); send(1, 1); send(1, 1); send(1, 1);
        @(posedge clk); #1;

        // 3: backpressure with a product waiting
        acc_ready[0] = 1'b0;
        send(0, 5); send(0, 5); send(0, 5); send(0, 5);
        p_valid[0] = 1'b1;
        p_data[0]  = 8'd7;
        repeat (6) begin
            @(negedge clk);
            check("t3_p_ready_low", 32'(p_ready[0]), 32'd0);
            check("t3_data_stable", 32'(acc_data_a), 32'd20);
            check("t3_valid_held", 32'(acc_valid[0]), 32'd1);
        end
        @(posedge clk); #1;
        acc_ready[0] = 1'b1;
        @(negedge clk);
        check("t3_no_bypass", 32'(p_ready[0]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t3_ready_back", 32'(p_ready[0]), 32'd1);
        model_add(0, 7);
        @(posedge clk); #1;
        p_valid[0] = 1'b0;
        send(0, 1); send(0, 1); send(0, 1);
        @(posedge clk); #1;

        // 4: bubbles between accepts
        for (int i = 0; i < 7; i++) begin
            if (bv[i] != 0) begin
                send(0, bd[i]);
            end else begin
                p_valid[0] = 1'b0;
                p_data[0]  = 8'($urandom);
                @(posedge clk); #1;
                check("t4_no_early_valid", 32'(acc_valid[0]), 32'd0);
            end
        end
        @(posedge clk); #1;

        // 5: clear drops a partial block and the offered product
        send(0, 50); send(0, 60);
        clear      = 1'b1;
        p_valid[0] = 1'b1;
        p_data[0]  = 8'd70;
        @(posedge clk); #1;
        clear      = 1'b0;
        p_valid[0] = 1'b0;
        m_cnt[0]   = 0;
        check("t5_acc_cleared", 32'(acc_data_a), 32'd0);
        send(0, 1); send(0, 2); send(0, 3); send(0, 4);
        @(posedge clk); #1;
        // clear while holding a result, with acc_ready asserted
        acc_ready[0] = 1'b0;
        send(0, 1); send(0, 1); send(0, 1); send(0, 1);
        check("t5_hold_valid", 32'(acc_valid[0]), 32'd1);
        acc_ready[0] = 1'b1;
        clear        = 1'b1;
        void'(exp_q0.pop_back());
        @(posedge clk); #1;
        clear = 1'b0;
        check("t5_hold_cleared", 32'(acc_valid[0]), 32'd0);
        check("t5_ovf_cleared", 32'(acc_ovf[0]), 32'd0);
        check("t5_ready_after", 32'(p_ready[0]), 32'd1);

        // 6: asynchronous reset mid-block
        send(0, 3); send(0, 3);
        #3;
        check("t6_partial", 32'(acc_data_a), 32'd6);
        rst = 1'b1;
        #1;
        check("t6_async_data", 32'(acc_data_a), 32'd0);
        check("t6_async_valid", 32'(acc_valid[0]), 32'd0);
        check("t6_async_ready", 32'(p_ready[0]), 32'd1);
        m_cnt[0] = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        send(0, 9); send(0, 9); send(0, 9); send(0, 9);
        repeat (3) @(posedge clk);
        #1;

        check("q_a_drained", 32'(exp_q0.size()), 32'd0);
        check("q_b_drained", 32'(exp_q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
